// File: rtl/ctrl_regfile_v2_if.sv
// rtl/ctrl_regfile_v2_if.sv - register-access bus between serial front end and control register file
interface ctrl_regfile_v2_if;
   logic [6:0] reg_num;
   logic       reg_write;
   logic [7:0] reg_data_write;
   logic [7:0] reg_data_read;

   modport master (
      output reg_num,
      output reg_write,
      output reg_data_write,
      input  reg_data_read
   );

   modport slave (
      input  reg_num,
      input  reg_write,
      input  reg_data_write,
      output reg_data_read
   );
endinterface

// File: rtl/ctrl_regfile_v2.sv
// rtl/ctrl_regfile_v2.sv - acquisition control register file with sticky status, reset pulser and LED PWM
module ctrl_regfile_v2 #(
   parameter int         NUM_CHANNELS = 16,
   parameter int         DIV_WIDTH    = 16,
   parameter int         PWM_BITS     = 18,
   parameter int         RST_PULSE    = 16,
   parameter logic [7:0] VERSION      = 8'h20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ctrl_regfile_v2_if.slave        bus,
   input  logic                    fifo_overflow,
   input  logic                    clklock,
   output logic                    led_out,
   output logic                    acq_enable,
   output logic                    acq_reset,
   output logic                    clock_select,
   output logic [DIV_WIDTH-1:0]    clock_divisor,
   output logic [NUM_CHANNELS-1:0] channel_enable
);

   localparam int DIV_BYTES = DIV_WIDTH / 8;
   localparam int CH_BYTES  = NUM_CHANNELS / 8;

   localparam logic [6:0] ADDR_VERSION = 7'h00;
   localparam logic [6:0] ADDR_STATUS  = 7'h01;
   localparam logic [6:0] ADDR_MODE    = 7'h02;
   localparam logic [6:0] ADDR_LED     = 7'h03;
   localparam int         ADDR_DIV0    = 4;
   localparam int         ADDR_CH0     = 16;

   // state registers
   logic                    lock_meta_q,     lock_meta_d;
   logic                    lock_sync_q,     lock_sync_d;
   logic                    ovf_sticky_q,    ovf_sticky_d;
   logic                    lock_lost_q,     lock_lost_d;
   logic                    acq_enable_q,    acq_enable_d;
   logic [7:0]              pulse_cnt_q,     pulse_cnt_d;
   logic                    clock_select_q,  clock_select_d;
   logic                    auto_stop_q,     auto_stop_d;
   logic [7:0]              brightness_q,    brightness_d;
   logic [DIV_WIDTH-1:0]    div_shadow_q,    div_shadow_d;
   logic [DIV_WIDTH-1:0]    clock_divisor_q, clock_divisor_d;
   logic [NUM_CHANNELS-1:0] channel_en_q,    channel_en_d;
   logic [PWM_BITS-1:0]     pwm_cnt_q,       pwm_cnt_d;

   // write strobes per register
   logic                    wr_status;
   logic                    wr_mode;
   logic                    wr_led;
   logic [DIV_BYTES-1:0]    wr_div_byte;
   logic [CH_BYTES-1:0]     wr_ch_byte;
   logic                    cfg_locked;
   logic                    pulse_active;
   logic                    lock_fall;
   logic [7:0]              wdata;

   assign wdata        = bus.reg_data_write;
   assign cfg_locked   = acq_enable_q;
   assign pulse_active = (pulse_cnt_q != 8'd0);
   // lock_sync is about to drop on this edge: it is 1 now and the first stage already saw 0
   assign lock_fall    = lock_sync_q & ~lock_meta_q;

   // address decode into per-register write strobes
   always_comb begin
      wr_status   = bus.reg_write && (bus.reg_num == ADDR_STATUS);
      wr_mode     = bus.reg_write && (bus.reg_num == ADDR_MODE);
      wr_led      = bus.reg_write && (bus.reg_num == ADDR_LED);
      wr_div_byte = '0;
      wr_ch_byte  = '0;
      for (int k = 0; k < DIV_BYTES; k++) begin
         wr_div_byte[k] = bus.reg_write && (bus.reg_num == 7'(ADDR_DIV0 + k));
      end
      for (int k = 0; k < CH_BYTES; k++) begin
         wr_ch_byte[k] = bus.reg_write && (bus.reg_num == 7'(ADDR_CH0 + k));
      end
   end

   // next-state for every register: sticky bits, enable, pulse counter, config, PWM
   always_comb begin
      lock_meta_d     = clklock;
      lock_sync_d     = lock_meta_q;
      ovf_sticky_d    = fifo_overflow | (ovf_sticky_q & ~(wr_status & wdata[0]));
      lock_lost_d     = lock_fall | (lock_lost_q & ~(wr_status & wdata[4]));
      acq_enable_d    = acq_enable_q;
      pulse_cnt_d     = pulse_cnt_q;
      clock_select_d  = clock_select_q;
      auto_stop_d     = auto_stop_q;
      brightness_d    = brightness_q;
      div_shadow_d    = div_shadow_q;
      clock_divisor_d = clock_divisor_q;
      channel_en_d    = channel_en_q;
      pwm_cnt_d       = pwm_cnt_q + 1'b1;

      // starting a reset pulse always drops acquisition, whatever b2 says
      if (wr_status) begin
         acq_enable_d = wdata[2] & ~wdata[3];
      end
      if (auto_stop_q && fifo_overflow) begin
         acq_enable_d = 1'b0;
      end

      if (wr_status && wdata[3]) begin
         pulse_cnt_d = 8'(RST_PULSE);
      end else if (pulse_active) begin
         pulse_cnt_d = pulse_cnt_q - 8'd1;
      end

      if (wr_mode) begin
         auto_stop_d = wdata[1];
         if (!cfg_locked) begin
            clock_select_d = wdata[0];
         end
      end

      if (wr_led) begin
         brightness_d = wdata;
      end

      // sample-path configuration is frozen while acquiring
      if (!cfg_locked) begin
         for (int k = 0; k < DIV_BYTES; k++) begin
            if (wr_div_byte[k]) begin
               div_shadow_d[8*k +: 8] = wdata;
            end
         end
         // the top byte commits the whole shadow so the divisor never shows a half-updated value
         if (wr_div_byte[DIV_BYTES-1]) begin
            clock_divisor_d = div_shadow_d;
         end
         for (int k = 0; k < CH_BYTES; k++) begin
            if (wr_ch_byte[k]) begin
               channel_en_d[8*k +: 8] = wdata;
            end
         end
      end
   end

   // register update with asynchronous clear of every flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q     <= 1'b0;
         lock_sync_q     <= 1'b0;
         ovf_sticky_q    <= 1'b0;
         lock_lost_q     <= 1'b0;
         acq_enable_q    <= 1'b0;
         pulse_cnt_q     <= 8'd0;
         clock_select_q  <= 1'b0;
         auto_stop_q     <= 1'b0;
         brightness_q    <= 8'd0;
         div_shadow_q    <= '0;
         clock_divisor_q <= '0;
         channel_en_q    <= '0;
         pwm_cnt_q       <= '0;
      end else begin
         lock_meta_q     <= lock_meta_d;
         lock_sync_q     <= lock_sync_d;
         ovf_sticky_q    <= ovf_sticky_d;
         lock_lost_q     <= lock_lost_d;
         acq_enable_q    <= acq_enable_d;
         pulse_cnt_q     <= pulse_cnt_d;
         clock_select_q  <= clock_select_d;
         auto_stop_q     <= auto_stop_d;
         brightness_q    <= brightness_d;
         div_shadow_q    <= div_shadow_d;
         clock_divisor_q <= clock_divisor_d;
         channel_en_q    <= channel_en_d;
         pwm_cnt_q       <= pwm_cnt_d;
      end
   end

   // combinational read-back of the addressed register
   always_comb begin
      bus.reg_data_read = 8'h00;
      case (bus.reg_num)
         ADDR_VERSION: bus.reg_data_read = VERSION;
         ADDR_STATUS:  bus.reg_data_read = {3'b000, lock_lost_q, pulse_active,
                                            acq_enable_q, lock_sync_q, ovf_sticky_q};
         ADDR_MODE:    bus.reg_data_read = {6'b000000, auto_stop_q, clock_select_q};
         ADDR_LED:     bus.reg_data_read = brightness_q;
         default:      bus.reg_data_read = 8'h00;
      endcase
      for (int k = 0; k < DIV_BYTES; k++) begin
         if (bus.reg_num == 7'(ADDR_DIV0 + k)) begin
            bus.reg_data_read = div_shadow_q[8*k +: 8];
         end
      end
      for (int k = 0; k < CH_BYTES; k++) begin
         if (bus.reg_num == 7'(ADDR_CH0 + k)) begin
            bus.reg_data_read = channel_en_q[8*k +: 8];
         end
      end
   end

   // outputs; acq_reset also covers the time the block itself is held in reset
   assign acq_enable     = acq_enable_q;
   assign acq_reset      = pulse_active | ~rst_n;
   assign clock_select   = clock_select_q;
   assign clock_divisor  = clock_divisor_q;
   assign channel_enable = channel_en_q;
   assign led_out        = ~(pwm_cnt_q[PWM_BITS-1 -: 8] < brightness_q);

endmodule

// File: tb/tb_ctrl_regfile_v2.sv
// tb/tb_ctrl_regfile_v2.sv - scoreboard bench for ctrl_regfile_v2
module tb_ctrl_regfile_v2;

   localparam int S_RD     = 0;
   localparam int S_DIV    = 1;
   localparam int S_CH     = 2;
   localparam int S_EN     = 3;
   localparam int S_RST    = 4;
   localparam int S_LED    = 5;
   localparam int S_CSEL   = 6;
   localparam int S_LEDCNT = 7;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   logic        clk;
   logic        rst_n;
   logic        fifo_overflow;
   logic        clklock;
   logic        led_out;
   logic        acq_enable;
   logic        acq_reset;
   logic        clock_select;
   logic [15:0] clock_divisor;
   logic [15:0] channel_enable;

   ctrl_regfile_v2_if bus ();

   ctrl_regfile_v2 #(
      .NUM_CHANNELS (16),
      .DIV_WIDTH    (16),
      .PWM_BITS     (10),
      .RST_PULSE    (16),
      .VERSION      (8'h20)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .fifo_overflow  (fifo_overflow),
      .clklock        (clklock),
      .led_out        (led_out),
      .acq_enable     (acq_enable),
      .acq_reset      (acq_reset),
      .clock_select   (clock_select),
      .clock_divisor  (clock_divisor),
      .channel_enable (channel_enable)
   );

   chk_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   led_low_cnt = 0;
   chk_t mon_c;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_RD:     return 32'(bus.reg_data_read);
         S_DIV:    return 32'(clock_divisor);
         S_CH:     return 32'(channel_enable);
         S_EN:     return 32'(acq_enable);
         S_RST:    return 32'(acq_reset);
         S_LED:    return 32'(led_out);
         S_CSEL:   return 32'(clock_select);
         S_LEDCNT: return 32'(led_low_cnt);
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   // monitor: compares every pending expectation against the DUT away from the active edge
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         mon_c = sb.pop_front();
         total++;
         if (observe(mon_c.sel) !== mon_c.exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", mon_c.name, observe(mon_c.sel), mon_c.exp);
         end
      end
   end

   task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      sb.push_back(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input logic [6:0] addr, input logic [7:0] data);
      bus.reg_num        = addr;
      bus.reg_data_write = data;
      bus.reg_write      = 1'b1;
      tick();
      bus.reg_write      = 1'b0;
   endtask

   task automatic chk_rd(input string name, input logic [6:0] addr, input logic [7:0] exp);
      bus.reg_num = addr;
      expect_val(name, S_RD, 32'(exp));
      settle();
   endtask

   task automatic count_led();
      led_low_cnt = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         if (led_out == 1'b0) led_low_cnt++;
      end
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n              = 1'b0;
      clklock            = 1'b1;
      fifo_overflow      = 1'b0;
      bus.reg_num        = 7'h00;
      bus.reg_write      = 1'b0;
      bus.reg_data_write = 8'h00;
      tick();
      tick();

      expect_val("rst_acq_reset", S_RST, 1);
      expect_val("rst_led", S_LED, 1);
      expect_val("rst_acq_en", S_EN, 0);
      expect_val("rst_csel", S_CSEL, 0);
      expect_val("rst_div", S_DIV, 0);
      expect_val("rst_ch", S_CH, 0);
      chk_rd("rd_version_rst", 7'h00, 8'h20);

      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk_rd("status_after_lock", 7'h01, 8'h02);
      chk_rd("rd_unmapped_7f", 7'h7F, 8'h00);
      chk_rd("rd_div0_rst", 7'h04, 8'h00);

      // divisor shadow and commit on top byte
      wr(7'h04, 8'h34);
      expect_val("div_no_commit", S_DIV, 32'h0000);
      chk_rd("rd_div0_shadow", 7'h04, 8'h34);
      wr(7'h05, 8'h12);
      expect_val("div_commit", S_DIV, 32'h1234);
      chk_rd("rd_div1_shadow", 7'h05, 8'h12);

      wr(7'h02, 8'h01);
      expect_val("csel_set", S_CSEL, 1);
      chk_rd("rd_mode", 7'h02, 8'h01);

      // configuration frozen while acquiring
      wr(7'h01, 8'h04);
      expect_val("acq_en_set", S_EN, 1);
      chk_rd("status_acq", 7'h01, 8'h06);
      wr(7'h10, 8'hFF);
      expect_val("ch_locked", S_CH, 0);
      wr(7'h04, 8'h99);
      wr(7'h05, 8'h77);
      expect_val("div_locked", S_DIV, 32'h1234);
      chk_rd("rd_div0_locked", 7'h04, 8'h34);
      wr(7'h02, 8'h00);
      expect_val("csel_locked", S_CSEL, 1);
      chk_rd("rd_mode_locked", 7'h02, 8'h01);

      // reset pulse with b2 also set: enable must still drop
      wr(7'h01, 8'h0C);
      bus.reg_num = 7'h01;
      for (int i = 0; i < 20; i++) begin
         expect_val($sformatf("pulse_%0d", i), S_RST, (i < 16) ? 1 : 0);
         if (i == 0) begin
            expect_val("pulse_acq_en", S_EN, 0);
            expect_val("pulse_status", S_RD, 32'h0A);
         end
         tick();
      end

      wr(7'h10, 8'hA5);
      expect_val("ch_byte0", S_CH, 32'h00A5);
      wr(7'h11, 8'h3C);
      expect_val("ch_byte1", S_CH, 32'h3CA5);
      chk_rd("rd_ch1", 7'h11, 8'h3C);
      chk_rd("rd_ch_unmapped", 7'h12, 8'h00);
      wr(7'h00, 8'hFF);
      chk_rd("rd_version_ro", 7'h00, 8'h20);

      // reload during an active pulse
      wr(7'h01, 8'h08);
      repeat (5) tick();
      wr(7'h01, 8'h08);
      for (int i = 0; i < 18; i++) begin
         expect_val($sformatf("reload_%0d", i), S_RST, (i < 16) ? 1 : 0);
         tick();
      end

      // auto_stop on overflow, sticky set wins over clear
      wr(7'h02, 8'h02);
      expect_val("csel_clear", S_CSEL, 0);
      wr(7'h01, 8'h04);
      expect_val("acq_en_before_ovf", S_EN, 1);
      fifo_overflow = 1'b1;
      tick();
      fifo_overflow = 1'b0;
      expect_val("ovf_autostop", S_EN, 0);
      chk_rd("status_ovf", 7'h01, 8'h03);
      fifo_overflow = 1'b1;
      wr(7'h01, 8'h01);
      fifo_overflow = 1'b0;
      chk_rd("ovf_set_wins", 7'h01, 8'h03);
      fifo_overflow = 1'b1;
      wr(7'h01, 8'h05);
      fifo_overflow = 1'b0;
      expect_val("autostop_over_write", S_EN, 0);
      chk_rd("ovf_still_set", 7'h01, 8'h03);
      wr(7'h01, 8'h01);
      chk_rd("ovf_cleared", 7'h01, 8'h02);

      // lock loss through the synchronizer
      clklock = 1'b0;
      tick();
      chk_rd("lock_stage1", 7'h01, 8'h02);
      tick();
      chk_rd("lock_lost", 7'h01, 8'h10);
      clklock = 1'b1;
      wr(7'h01, 8'h10);
      chk_rd("lost_cleared", 7'h01, 8'h00);
      tick();
      chk_rd("relock", 7'h01, 8'h02);

      // LED PWM duty
      wr(7'h03, 8'h80);
      chk_rd("rd_bright", 7'h03, 8'h80);
      count_led();
      expect_val("led_duty_80", S_LEDCNT, 512);
      settle();
      wr(7'h03, 8'h00);
      count_led();
      expect_val("led_duty_00", S_LEDCNT, 0);
      settle();
      wr(7'h03, 8'hFF);
      count_led();
      expect_val("led_duty_ff", S_LEDCNT, 1020);
      settle();

      // reset in the middle of a pulse
      wr(7'h01, 8'h08);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      expect_val("midrst_acq_reset", S_RST, 1);
      expect_val("midrst_led", S_LED, 1);
      expect_val("midrst_div", S_DIV, 0);
      expect_val("midrst_ch", S_CH, 0);
      chk_rd("midrst_bright", 7'h03, 8'h00);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         expect_val($sformatf("post_rst_%0d", i), S_RST, 0);
         tick();
      end

      tick();
      tick();
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
